// File: rtl/circuit1_result_acc.sv
// Frame accumulator for CIRCUIT1 (x, z) results: saturating sum of x plus min/max of z
// over NSAMP accepted pairs, each completed frame held in a single-entry output buffer.
module circuit1_result_acc #(
    parameter int unsigned XW    = 16,
    parameter int unsigned ZW    = 8,
    parameter int unsigned NSAMP = 8,
    parameter int unsigned ACCW  = 24
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            clr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XW-1:0]   x,
    input  logic [ZW-1:0]   z,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] sum,
    output logic [ZW-1:0]   zmax,
    output logic [ZW-1:0]   zmin,
    output logic            ovf
);

    localparam int unsigned CW = (NSAMP > 2) ? $clog2(NSAMP) : 1;

    typedef enum logic {
        ACCUM = 1'b0,
        LAST  = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [ACCW-1:0] acc, acc_nxt;
    logic [ZW-1:0]   wmax, wmax_nxt;
    logic [ZW-1:0]   wmin, wmin_nxt;
    logic            wovf, wovf_nxt;

    logic [ACCW-1:0] sum_nxt;
    logic [ZW-1:0]   zmax_nxt, zmin_nxt;
    logic            ovf_nxt, out_valid_nxt;

    logic [ACCW:0]   add_full;
    logic [ACCW-1:0] acc_upd;
    logic            ovf_upd;
    logic [ZW-1:0]   max_upd, min_upd;
    logic            accept, xfer;

    // Only the final sample of a frame can be blocked, and only by an unread frame.
    assign in_ready = ~clr & ~((state == LAST) & out_valid & ~out_ready);
    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid & out_ready;

    // Running values including the sample currently offered.
    always_comb begin
        add_full = {1'b0, acc} + (ACCW+1)'(x);
        acc_upd  = add_full[ACCW] ? {ACCW{1'b1}} : add_full[ACCW-1:0];
        ovf_upd  = wovf | add_full[ACCW];
        max_upd  = (z > wmax) ? z : wmax;
        min_upd  = (z < wmin) ? z : wmin;
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        acc_nxt       = acc;
        wmax_nxt      = wmax;
        wmin_nxt      = wmin;
        wovf_nxt      = wovf;
        sum_nxt       = sum;
        zmax_nxt      = zmax;
        zmin_nxt      = zmin;
        ovf_nxt       = ovf;
        out_valid_nxt = out_valid & ~xfer;

        if (clr) begin
            state_nxt = ACCUM;
            cnt_nxt   = '0;
            acc_nxt   = '0;
            wmax_nxt  = '0;
            wmin_nxt  = '1;
            wovf_nxt  = 1'b0;
        end else if (accept) begin
            if (state == LAST) begin
                // Final sample: publish the frame and restart the working set.
                sum_nxt       = acc_upd;
                zmax_nxt      = max_upd;
                zmin_nxt      = min_upd;
                ovf_nxt       = ovf_upd;
                out_valid_nxt = 1'b1;
                state_nxt     = ACCUM;
                cnt_nxt       = '0;
                acc_nxt       = '0;
                wmax_nxt      = '0;
                wmin_nxt      = '1;
                wovf_nxt      = 1'b0;
            end else begin
                acc_nxt  = acc_upd;
                wmax_nxt = max_upd;
                wmin_nxt = min_upd;
                wovf_nxt = ovf_upd;
                cnt_nxt  = cnt + CW'(1);
                if (cnt == CW'(NSAMP - 2)) begin
                    state_nxt = LAST;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt       <= '0;
            acc       <= '0;
            wmax      <= '0;
            wmin      <= '1;
            wovf      <= 1'b0;
            sum       <= '0;
            zmax      <= '0;
            zmin      <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            acc       <= acc_nxt;
            wmax      <= wmax_nxt;
            wmin      <= wmin_nxt;
            wovf      <= wovf_nxt;
            sum       <= sum_nxt;
            zmax      <= zmax_nxt;
            zmin      <= zmin_nxt;
            ovf       <= ovf_nxt;
            out_valid <= out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_circuit1_result_acc.sv
// Directed bench for circuit1_result_acc: a 16-bit accumulator instance and a 24-bit
// one share all inputs; expected values are hand-computed per vector.
module tb_circuit1_result_acc;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] x = '0;
    logic [7:0]  z = '0;
    logic        out_ready = 1'b1;

    logic        rdy_a, ov_a, ovf_a;
    logic [15:0] sum_a;
    logic [7:0]  zmax_a, zmin_a;
    logic        rdy_b, ov_b, ovf_b;
    logic [23:0] sum_b;
    logic [7:0]  zmax_b, zmin_b;

    int nvec = 0;
    int nerr = 0;

    always #5 Clk = ~Clk;

    circuit1_result_acc #(.XW(16), .ZW(8), .NSAMP(8), .ACCW(16)) dut_a (
        .Clk(Clk), .Rst(Rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy_a),
        .x(x), .z(z), .out_valid(ov_a), .out_ready(out_ready),
        .sum(sum_a), .zmax(zmax_a), .zmin(zmin_a), .ovf(ovf_a)
    );

    circuit1_result_acc #(.XW(16), .ZW(8), .NSAMP(8), .ACCW(24)) dut_b (
        .Clk(Clk), .Rst(Rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy_b),
        .x(x), .z(z), .out_valid(ov_b), .out_ready(out_ready),
        .sum(sum_b), .zmax(zmax_b), .zmin(zmin_b), .ovf(ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Offer one pair and hold it until accepted (bounded), leaving in_valid asserted.
    task automatic push(input logic [15:0] xv, input logic [7:0] zv);
        int n;
        n = 0;
        in_valid = 1'b1;
        x = xv;
        z = zv;
        #1;
        while (!rdy_a && n < 50) begin
            tick();
            n++;
        end
        if (!rdy_a) chk("push_timeout", 32'(rdy_a), 32'd1);
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    logic [7:0] zt [8];

    initial begin
        zt[0] = 8'd5; zt[1] = 8'd9; zt[2] = 8'd2;   zt[3] = 8'd7;
        zt[4] = 8'd7; zt[5] = 8'd3; zt[6] = 8'd250; zt[7] = 8'd4;

        // Reset state
        #12;
        Rst = 1'b1;
        #1;
        chk("rst_ready", 32'(rdy_a), 32'd1);
        chk("rst_valid", 32'(ov_a), 32'd0);
        chk("rst_sum", 32'(sum_a), 32'd0);
        chk("rst_zmax", 32'(zmax_a), 32'd0);
        chk("rst_zmin", 32'(zmin_a), 32'd0);
        chk("rst_ovf", 32'(ovf_a), 32'd0);
        tick();

        // Basic frame
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            push(16'(i + 1), zt[i]);
            chk("basic_nolead", 32'(ov_a), 32'd0);
        end
        push(16'd8, zt[7]);
        chk("basic_valid", 32'(ov_a), 32'd1);
        chk("basic_sum", 32'(sum_a), 32'd36);
        chk("basic_sum24", 32'(sum_b), 32'd36);
        chk("basic_zmax", 32'(zmax_a), 32'd250);
        chk("basic_zmin", 32'(zmin_a), 32'd2);
        chk("basic_ovf", 32'(ovf_a), 32'd0);
        idle();
        chk("basic_onecyc", 32'(ov_a), 32'd0);
        chk("basic_hold", 32'(sum_a), 32'd36);

        // Reset mid-frame after 3 samples
        for (int i = 0; i < 3; i++) push(16'd50, 8'd1);
        in_valid = 1'b0;
        #2;
        Rst = 1'b0;
        #1;
        chk("mrst_valid", 32'(ov_a), 32'd0);
        chk("mrst_sum", 32'(sum_a), 32'd0);
        chk("mrst_zmin", 32'(zmin_a), 32'd0);
        chk("mrst_ready", 32'(rdy_b), 32'd1);
        #2;
        Rst = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) push(16'd3, 8'(i + 10));
        chk("mrst_fvalid", 32'(ov_a), 32'd1);
        chk("mrst_fsum", 32'(sum_a), 32'd24);
        chk("mrst_fzmax", 32'(zmax_a), 32'd17);
        chk("mrst_fzmin", 32'(zmin_a), 32'd10);
        idle();

        // Back-to-back frames, one sample per cycle
        for (int i = 0; i < 24; i++) begin
            in_valid = 1'b1;
            x = 16'd1000;
            z = 8'(i);
            #1;
            chk("b2b_ready", 32'(rdy_a), 32'd1);
            tick();
            if (i % 8 == 7) begin
                chk("b2b_valid", 32'(ov_a), 32'd1);
                chk("b2b_sum", 32'(sum_a), 32'd8000);
                chk("b2b_zmax", 32'(zmax_a), 32'(i));
                chk("b2b_zmin", 32'(zmin_a), 32'(i - 7));
            end else if (i % 8 == 0 && i > 0) begin
                chk("b2b_drop", 32'(ov_a), 32'd0);
            end
        end
        idle();

        // Backpressure across two frames
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(16'd10, 8'd3);
        chk("bp_valid1", 32'(ov_a), 32'd1);
        chk("bp_sum1", 32'(sum_a), 32'd80);
        for (int i = 0; i < 7; i++) push(16'd10, 8'd4);
        in_valid = 1'b1;
        x = 16'd10;
        z = 8'd4;
        #1;
        chk("bp_stall", 32'(rdy_a), 32'd0);
        tick();
        tick();
        chk("bp_hold_sum", 32'(sum_a), 32'd80);
        chk("bp_hold_zmax", 32'(zmax_a), 32'd3);
        chk("bp_hold_valid", 32'(ov_a), 32'd1);
        chk("bp_stall2", 32'(rdy_a), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release", 32'(rdy_a), 32'd1);
        tick();
        chk("bp_valid2", 32'(ov_a), 32'd1);
        chk("bp_sum2", 32'(sum_a), 32'd80);
        chk("bp_zmax2", 32'(zmax_a), 32'd4);
        idle();
        chk("bp_drain", 32'(ov_a), 32'd0);

        // Saturation
        for (int i = 0; i < 8; i++) push(16'hFFFF, 8'd0);
        chk("sat_sum16", 32'(sum_a), 32'h0000FFFF);
        chk("sat_ovf16", 32'(ovf_a), 32'd1);
        chk("sat_sum24", 32'(sum_b), 32'd524280);
        chk("sat_ovf24", 32'(ovf_b), 32'd0);
        for (int i = 0; i < 8; i++) push(16'd1, 8'd0);
        out_ready = 1'b0;
        chk("sat_next_sum", 32'(sum_a), 32'd8);
        chk("sat_next_ovf", 32'(ovf_a), 32'd0);

        // clr drops partial frame; held frame (sum=8) untouched
        for (int i = 0; i < 5; i++) push(16'd100, 8'd9);
        clr = 1'b1;
        in_valid = 1'b1;
        x = 16'd100;
        #1;
        chk("clr_ready", 32'(rdy_a), 32'd0);
        tick();
        clr = 1'b0;
        chk("clr_keep_valid", 32'(ov_a), 32'd1);
        chk("clr_keep_sum", 32'(sum_a), 32'd8);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(16'd2, 8'd5);
        chk("clr_valid", 32'(ov_a), 32'd1);
        chk("clr_sum", 32'(sum_a), 32'd16);
        chk("clr_sum24", 32'(sum_b), 32'd16);
        chk("clr_zmax", 32'(zmax_a), 32'd5);
        chk("clr_zmin", 32'(zmin_a), 32'd5);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/circuit1_result_acc.md
# circuit1_result_acc

Downstream consumer of the CIRCUIT1 datapath. Accepts one (x, z) result pair per cycle over a valid/ready handshake, accumulates NSAMP pairs into a frame (sum of x, min and max of z, overflow flag), and presents each completed frame on a registered output with its own valid/ready handshake. Single-entry output buffer: accumulation of the next frame continues while the previous frame waits for the consumer.

## Interface
- XW, 16, width of x input (matches CIRCUIT1 x)
- ZW, 8, width of z input (matches CIRCUIT1 z)
- NSAMP, 8, samples per frame; legal range 2..255
- ACCW, 24, width of sum accumulator and sum output; must be ≥ XW

- Clk  in  1  system clock, all state updates on rising edge
- Rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous discard of the partial frame in progress
- in_valid  in  1  x/z pair present
- in_ready  out  1  block can accept pair this cycle
- x  in  XW  CIRCUIT1 x result, unsigned
- z  in  ZW  CIRCUIT1 z result, unsigned
- out_valid  out  1  completed frame present
- out_ready  in  1  consumer takes frame this cycle
- sum  out  ACCW  sum of x over frame, unsigned, saturating
- zmax  out  ZW  maximum z over frame
- zmin  out  ZW  minimum z over frame
- ovf  out  1  sum saturated during this frame

## Operation
- Accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Working registers: acc (ACCW), wmax (ZW), wmin (ZW), wovf, cnt (counts 0..NSAMP-1).
- On accept with cnt < NSAMP-1: acc ← acc + x (zero-extended); if the true sum exceeds 2^ACCW-1, acc ← all ones and wovf ← 1. wmax ← max(wmax, z); wmin ← min(wmin, z); cnt ← cnt+1.
- On accept with cnt == NSAMP-1 (final sample): final values (including this sample) are loaded into sum/zmax/zmin/ovf, out_valid ← 1; working registers restart at acc=0, wmax=0, wmin=all ones, wovf=0, cnt=0.
- Two states: ACCUM (cnt < NSAMP-1) and LAST (cnt == NSAMP-1); LAST → ACCUM on final accept or clr.
- in_ready = ~clr & ~(state==LAST & out_valid & ~out_ready). The final sample is stalled only while the previous frame is still unread; non-final samples always accepted.
- out_valid clears on output transfer unless a new frame loads in the same cycle, in which case out_valid stays 1 and outputs take the new frame.
- clr: working registers return to restart values next edge; no sample accepted that cycle (in_ready=0); output registers and out_valid unaffected.
- Output registers hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset (Rst=0, immediate): in_ready=1 after release, out_valid=0, sum=0, zmax=0, zmin=0, ovf=0, cnt=0, acc=0, wmax=0, wmin=all ones, wovf=0.
- Reset mid-frame discards partial frame and any unread output frame.
- Throughput: one sample per cycle sustained when consumer keeps out_ready=1.
- Latency: out_valid rises on the edge that accepts the final sample; frame visible the following cycle.
- in_ready is combinational from out_ready, out_valid, state, clr; all other outputs registered.
- Simultaneous final accept and output transfer in LAST: both occur; no bubble.

## Test plan
- Reset/idle: Rst low mid-frame after 3 samples -> out_valid=0, sum=0, zmin=0, in_ready=1; next 8 samples form a fresh frame.
- Basic frame (NSAMP=8): x=1..8, z={5,9,2,7,7,3,250,4}, out_ready=1 -> one cycle after 8th accept sum=36, zmax=250, zmin=2, ovf=0, out_valid high 1 cycle.
- Back-to-back: 24 consecutive samples x=1000, out_ready=1 -> three frames each sum=8000, in_ready never low.
- Backpressure: out_ready=0 through two frames of x=10 -> first frame held (sum=80), in_ready low at 8th sample of second frame; raise out_ready -> first frame transfers, 8th sample accepted same cycle, second frame sum=80 next cycle.
- Saturation (ACCW=16): 8 samples x=16'hFFFF -> sum=16'hFFFF, ovf=1; next frame x=1 -> sum=8, ovf=0.
- clr: 5 samples x=100 then clr with in_valid high -> that sample dropped; next 8 samples x=2 -> sum=16, output frame already present before clr unchanged.
